// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the fetch-stage PC controller.
package pc_fetch_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
   localparam logic [31:0] IMEM_LO      = 32'h0000_3000;
   localparam logic [31:0] IMEM_HI      = 32'h0000_6FFC;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_PEND = 1'b1
   } state_e;

endpackage

// File: rtl/pc_addr_check.sv
// Combinational fetch-address check: word alignment and instruction-memory window.
module pc_addr_check
   import pc_fetch_ctrl_pkg::*;
(
   input  logic [31:0] i_addr,
   output logic        o_adel
);

   logic w_misaligned;
   logic w_out_of_range;

   assign w_misaligned   = (i_addr[1:0] != 2'b00);
   assign w_out_of_range = (i_addr < IMEM_LO) || (i_addr > IMEM_HI);
   assign o_adel         = w_misaligned || w_out_of_range;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter: increment, stall hold, branch redirect (deferred
// across stalls), exception entry and eret return.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] EXC_PC   = EXC_PC_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] pc_F,
   output logic [31:0] pc4_F,
   output logic        adel_F,
   output logic        redirect_pending
);

   state_e      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_pend_target;
   logic        r_adel;

   state_e      w_state_next;
   logic [31:0] w_pc_next;
   logic [31:0] w_pend_next;
   logic        w_adel_next;

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_pend_next  = r_pend_target;
      if (exc_req) begin
         w_pc_next    = EXC_PC;
         w_state_next = S_RUN;
         w_pend_next  = 32'h0000_0000;
      end else if (eret_req) begin
         w_pc_next    = epc;
         w_state_next = S_RUN;
         w_pend_next  = 32'h0000_0000;
      end else if (stall) begin
         // Frozen F stage: latch the newest redirect so it survives the stall.
         if (br_valid) begin
            w_pend_next  = br_target;
            w_state_next = S_PEND;
         end else begin
            w_pend_next  = r_pend_target;
         end
      end else if (br_valid) begin
         w_pc_next    = br_target;
         w_state_next = S_RUN;
         w_pend_next  = 32'h0000_0000;
      end else if (r_state == S_PEND) begin
         w_pc_next    = r_pend_target;
         w_state_next = S_RUN;
         w_pend_next  = 32'h0000_0000;
      end else begin
         w_pc_next    = r_pc + 32'd4;
      end
   end

   pc_addr_check u_addr_check (
      .i_addr (w_pc_next),
      .o_adel (w_adel_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_RUN;
         r_pc          <= RESET_PC;
         r_pend_target <= 32'h0000_0000;
         r_adel        <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_pc          <= w_pc_next;
         r_pend_target <= w_pend_next;
         r_adel        <= w_adel_next;
      end
   end

   assign pc_F             = r_pc;
   assign pc4_F            = r_pc + 32'd4;
   assign adel_F           = r_adel;
   assign redirect_pending = (r_state == S_PEND);

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the fetch-stage program counter for the pipelined MIPS core.
- Sequences the PC register: sequential increment, stall hold, branch/jump redirect, exception entry and eret return.
- Sits between the decode-stage next-PC logic (target producer), the hazard unit (stall), CP0 (exc/eret/EPC) and instruction memory (PC consumer).
- Captures a single-cycle redirect pulse that arrives while fetch is stalled, and applies it when the stall releases.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_PC, 32'h0000_4180, exception handler entry address.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit freeze of the F stage.
- br_valid  input  1  single-cycle pulse: taken branch or jump resolved; delay slot already in F.
- br_target  input  32  redirect target, valid when br_valid=1.
- exc_req  input  1  CP0 exception entry request, one cycle.
- eret_req  input  1  eret commit request, one cycle.
- epc  input  32  return address, valid with eret_req.
- pc_F  output  32  current fetch PC, registered.
- pc4_F  output  32  pc_F + 4, combinational from pc_F.
- adel_F  output  1  registered; pc_F[1:0] != 0 or pc_F outside [0x3000, 0x6FFC].
- redirect_pending  output  1  high in state PEND.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset. All state updates on the rising edge of clk.
- Reset: pc_F=RESET_PC, adel_F=0, state=RUN, pend_target=0, redirect_pending=0. Reset wins over every other input in the same cycle. Reset asserted mid-PEND discards the captured target.
- States: RUN, PEND.
- Next-PC priority, evaluated each cycle in order:
  1. exc_req: pc_F<=EXC_PC; state<=RUN; pending target dropped. Applies even when stall=1.
  2. eret_req: pc_F<=epc; state<=RUN; pending target dropped. Applies even when stall=1.
  3. stall=1, br_valid=1: pend_target<=br_target; state<=PEND; pc_F holds.
  4. stall=1, br_valid=0: pc_F holds; state unchanged; pend_target unchanged.
  5. stall=0, br_valid=1: pc_F<=br_target; state<=RUN. A new pulse overrides any stale pending target.
  6. stall=0, state=PEND: pc_F<=pend_target; state<=RUN.
  7. Otherwise: pc_F<=pc_F+4.
- exc_req and eret_req asserted together: exc_req wins.
- br_valid while already in PEND and still stalled: pend_target is overwritten with the newest target.
- Latency:
  - A redirect in an unstalled cycle is visible on pc_F the next cycle.
  - A redirect captured during a stall is visible on pc_F the cycle after stall drops.
- Arithmetic: pc_F+4 is 32-bit modulo. Wrap from 0xFFFF_FFFC to 0x0000_0000 is legal and raises no flag other than adel_F.
- adel_F is recomputed from the value loaded into pc_F. The PC is still presented; the exception itself is raised downstream.
- redirect_pending = (state==PEND).

Decomposition:
- Shared package/header holds:
  - RESET_PC and EXC_PC defaults.
  - IMEM_LO = 0x3000 and IMEM_HI = 0x6FFC.
  - State encodings S_RUN = 1'b0, S_PEND = 1'b1.
- One sub-module, pc_addr_check: combinational alignment and range check feeding the adel_F register.
- Everything else is flat.

Test Plan:
- Reset then 3 free cycles -> pc_F = 0x3000, 0x3004, 0x3008, 0x300C; adel_F=0; redirect_pending=0.
- At pc_F=0x3010 with stall=0, br_valid=1, br_target=0x3100 -> next pc_F=0x3100, then 0x3104.
- stall=1 for 3 cycles; br_valid pulse in cycle 1 with target 0x3200 -> pc_F holds and redirect_pending=1 during the stall; first cycle after release pc_F=0x3200, redirect_pending=0.
- In PEND with stall=1, exc_req=1 -> next pc_F=0x4180, redirect_pending=0; after release pc_F=0x4184 (the pending 0x3200 is discarded).
- exc_req and eret_req together with epc=0x3008 -> pc_F=0x4180. Then eret_req alone -> pc_F=0x3008.
- br_target=0x3102 -> adel_F=1 with pc_F=0x3102. br_target=0x2FFC -> adel_F=1. Reset asserted during PEND -> pc_F=0x3000, adel_F=0, redirect_pending=0.
